// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: one write port, two read ports and the
// clear-engine handshake. The master drives requests and the slave returns data and status.
interface reg_file_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             wr;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] d_in;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] d_out_a;
  logic [WIDTH-1:0] d_out_b;
  logic             clr;
  logic             busy;
  logic             wr_drop;

  modport master (
    output wr, wr_addr, d_in, rd_addr_a, rd_addr_b, clr,
    input  d_out_a, d_out_b, busy, wr_drop
  );

  modport slave (
    input  wr, wr_addr, d_in, rd_addr_a, rd_addr_b, clr,
    output d_out_a, d_out_b, busy, wr_drop
  );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, an optional zero register and bypass, and a one-entry-per-cycle clear sweep.
module reg_file_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 0
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [AW-1:0]    r_ptr;
  logic             r_busy;
  logic             r_wr_drop;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_wr_accept;
  logic             w_wr_store;
  logic             w_clear_we;
  logic [AW-1:0]    w_ptr_next;
  logic             w_busy_next;
  logic             w_drop_next;
  logic             w_zero_a;
  logic             w_zero_b;
  logic             w_byp_a;
  logic             w_byp_b;

  assign w_wr_accept = bus.wr && (r_state == S_IDLE);
  // Writes to the zero register are accepted but never reach storage.
  assign w_wr_store  = w_wr_accept && !((ZERO_REG != 0) && (bus.wr_addr == '0));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every signal driven in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.clr) w_next_state = S_CLEAR;
      S_CLEAR: if (r_ptr == AW'(DEPTH - 1)) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_clear_we  = 1'b0;
    w_ptr_next  = r_ptr;
    w_busy_next = (w_next_state == S_CLEAR);
    w_drop_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr) w_ptr_next = '0;
      end
      S_CLEAR: begin
        w_clear_we  = 1'b1;
        w_ptr_next  = r_ptr + 1'b1;
        w_drop_next = bus.wr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr     <= '0;
      r_busy    <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_ptr     <= w_ptr_next;
      r_busy    <= w_busy_next;
      r_wr_drop <= w_drop_next;
    end
  end

  // NOTE: storage is reset because reset must leave every entry reading
  // zero with no clock; this rules out a RAM macro for this block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clear_we) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_store) begin
      r_mem[bus.wr_addr] <= bus.d_in;
    end
  end

  assign w_zero_a = (ZERO_REG != 0) && (bus.rd_addr_a == '0);
  assign w_zero_b = (ZERO_REG != 0) && (bus.rd_addr_b == '0);
  assign w_byp_a  = (BYPASS != 0) && w_wr_accept && (bus.rd_addr_a == bus.wr_addr);
  assign w_byp_b  = (BYPASS != 0) && w_wr_accept && (bus.rd_addr_b == bus.wr_addr);

  assign bus.d_out_a = w_zero_a ? '0 : (w_byp_a ? bus.d_in : r_mem[bus.rd_addr_a]);
  assign bus.d_out_b = w_zero_b ? '0 : (w_byp_b ? bus.d_in : r_mem[bus.rd_addr_b]);
  assign bus.busy    = r_busy;
  assign bus.wr_drop = r_wr_drop;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (plain, and zero-register + bypass)
// share one stimulus and are compared against a behavioural model every cycle.
module tb_reg_file_param;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] d_in = '0;
  logic [2:0]  rd_addr_a = '0;
  logic [2:0]  rd_addr_b = '0;
  logic        clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_file_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
  reg_file_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

  assign if0.wr = wr;        assign if1.wr = wr;
  assign if0.wr_addr = wr_addr;  assign if1.wr_addr = wr_addr;
  assign if0.d_in = d_in;    assign if1.d_in = d_in;
  assign if0.rd_addr_a = rd_addr_a; assign if1.rd_addr_a = rd_addr_a;
  assign if0.rd_addr_b = rd_addr_b; assign if1.rd_addr_b = rd_addr_b;
  assign if0.clr = clr;      assign if1.clr = clr;

  reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(0), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  // Model: contents per configuration, plus how many entries the sweep still owes.
  logic [15:0] m_mem [2][DEPTH];
  int          m_rem = 0;
  logic        m_drop = 1'b0;
  bit          cfg_zero [2] = '{1'b0, 1'b1};
  bit          cfg_byp  [2] = '{1'b0, 1'b1};

  initial for (int c = 0; c < 2; c++) for (int k = 0; k < DEPTH; k++) m_mem[c][k] = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) for (int k = 0; k < DEPTH; k++) m_mem[c][k] = '0;
      m_rem  = 0;
      m_drop = 1'b0;
    end else begin
      m_drop = wr && (m_rem > 0);
      if (m_rem > 0) begin
        for (int c = 0; c < 2; c++) m_mem[c][DEPTH - m_rem] = '0;
        m_rem = m_rem - 1;
      end else begin
        if (wr)
          for (int c = 0; c < 2; c++)
            if (!(cfg_zero[c] && wr_addr == 3'd0)) m_mem[c][wr_addr] = d_in;
        if (clr) m_rem = DEPTH;
      end
    end
  end

  function automatic logic [15:0] exp_read(input int c, input logic [2:0] addr);
    if (cfg_zero[c] && addr == 3'd0) return 16'h0000;
    if (cfg_byp[c] && wr && m_rem == 0 && addr == wr_addr) return d_in;
    return m_mem[c][addr];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cfg0_d_out_a", if0.d_out_a, exp_read(0, rd_addr_a));
    check("cfg0_d_out_b", if0.d_out_b, exp_read(0, rd_addr_b));
    check("cfg0_busy",    16'(if0.busy),    16'(m_rem > 0));
    check("cfg0_wr_drop", 16'(if0.wr_drop), 16'(m_drop));
    check("cfg1_d_out_a", if1.d_out_a, exp_read(1, rd_addr_a));
    check("cfg1_d_out_b", if1.d_out_b, exp_read(1, rd_addr_b));
    check("cfg1_busy",    16'(if1.busy),    16'(m_rem > 0));
    check("cfg1_wr_drop", 16'(if1.wr_drop), 16'(m_drop));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    wr = 1'b1; wr_addr = a; d_in = d;
    step();
    wr = 1'b0;
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < DEPTH; k++) do_write(3'(k), base + 16'(k));
  endtask

  task automatic start_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int busy_cnt;

    // 1: reset, basic writes and reads
    step(); step();
    #1 reset = 1'b0;
    step();
    do_write(3'd3, 16'hA5A5);
    do_write(3'd7, 16'h1234);
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    #1;
    check("t1_rd_a3", if0.d_out_a, 16'hA5A5);
    check("t1_rd_b7", if0.d_out_b, 16'h1234);
    rd_addr_a = 3'd0;
    #1 check("t1_rd_a0", if0.d_out_a, 16'h0000);

    // 2: zero register
    do_write(3'd0, 16'hFFFF);
    rd_addr_a = 3'd0;
    #1;
    check("t2_zero_rd", if1.d_out_a, 16'h0000);
    check("t2_zero_drop", 16'(if1.wr_drop), 16'h0000);
    check("t2_plain_rd0", if0.d_out_a, 16'hFFFF);
    do_write(3'd1, 16'h0F0F);
    rd_addr_a = 3'd1;
    #1 check("t2_rd1", if1.d_out_a, 16'h0F0F);

    // 3: bypass vs no bypass
    do_write(3'd5, 16'h1111);
    wr = 1'b1; wr_addr = 3'd5; d_in = 16'h2222; rd_addr_a = 3'd5;
    #1;
    check("t3_byp_same", if1.d_out_a, 16'h2222);
    check("t3_nobyp_same", if0.d_out_a, 16'h1111);
    step();
    wr = 1'b0;
    #1 check("t3_nobyp_after", if0.d_out_a, 16'h2222);

    // 4: full sweep timing
    fill(16'h0100);
    start_clear();
    busy_cnt = 0;
    for (int j = 0; j < 11; j++) begin
      rd_addr_a = 3'd7; rd_addr_b = 3'(j);
      #1;
      if (if0.busy) busy_cnt++;
      if (j == 7) check("t4_e7_cycle7", if0.d_out_a, 16'h0107);
      if (j == 3) check("t4_e3_cycle3", if0.d_out_b, 16'h0103);
      step();
    end
    check("t4_busy_cycles", 16'(busy_cnt), 16'd8);
    check("t4_e7_after", if0.d_out_a, 16'h0000);

    // 5: rejected write and ignored clr during the sweep
    fill(16'h0200);
    start_clear();
    busy_cnt = 0;
    for (int j = 0; j < 12; j++) begin
      wr = (j == 3);
      wr_addr = 3'd2; d_in = 16'hBEEF;
      clr = (j == 4);
      rd_addr_a = 3'd2; rd_addr_b = 3'd6;
      #1;
      if (if0.busy) busy_cnt++;
      if (j == 4) begin
        check("t5_drop_c4", 16'(if0.wr_drop), 16'h0001);
        check("t5_rd2_c4", if0.d_out_a, 16'h0000);
      end
      if (j == 5) check("t5_drop_c5", 16'(if0.wr_drop), 16'h0000);
      step();
    end
    wr = 1'b0; clr = 1'b0;
    check("t5_busy_cycles", 16'(busy_cnt), 16'd8);

    // 6: asynchronous reset mid-sweep
    fill(16'h0300);
    start_clear();
    step(); step();
    do_write(3'd1, 16'h5555);
    rd_addr_a = 3'd6; rd_addr_b = 3'd5;
    #1;
    check("t6_drop_pre", 16'(if0.wr_drop), 16'h0001);
    check("t6_rd6_pre", if0.d_out_a, 16'h0306);
    reset = 1'b1;
    #1;
    check("t6_busy_rst", 16'(if0.busy), 16'h0000);
    check("t6_drop_rst", 16'(if0.wr_drop), 16'h0000);
    check("t6_rd_a_rst", if0.d_out_a, 16'h0000);
    check("t6_rd_b_rst", if1.d_out_b, 16'h0000);
    @(posedge clk);
    #3 reset = 1'b0;
    step();
    do_write(3'd6, 16'h00AA);
    rd_addr_a = 3'd6;
    #1 check("t6_post_write", if0.d_out_a, 16'h00AA);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
